yin_tau_picker: RTL and testbench
=================================

// Module: yin_tau_picker
// PURPOSE
//  Reader stage for the normalized-difference vector produced by the modified-difference stage of the YIN pitch path.
//  On each new vector, scans tau upward from MIN_TAU, finds the first tau whose value is below a threshold,
//  then descends to the local minimum. Emits the period estimate (tau) with a one-cycle valid strobe.
//  If no value is below the threshold, emits the global-minimum tau with found=0.
// PARAMETERS
//  INTERMEDIATE_DATA_WIDTH  64  width of each normalized-difference entry and of threshold/min_value
//  MAX_TAU                  40  number of entries in results_in (tau = 0..MAX_TAU-1)
//  MIN_TAU                   2  first tau examined; entries below it are never read
//  TAU_BITS                  6  width of tau_out; must satisfy 2**TAU_BITS >= MAX_TAU
// PORTS
//  clk            in   1                          system clock, rising edge
//  reset          in   1                          asynchronous, active-high
//  results_in     in   MAX_TAU*INTERMEDIATE_DATA_WIDTH  entry tau at [tau*W +: W]
//  results_ready  in   1                          level; high while results_in is valid
//  threshold      in   INTERMEDIATE_DATA_WIDTH    same scaling as results_in entries; sampled at capture
//  busy           out  1                          high from the capture cycle until pitch_valid
//  pitch_valid    out  1                          one-cycle strobe; tau_out/found/min_value are valid this cycle
//  tau_out        out  TAU_BITS                   chosen period in samples
//  found          out  1                          1 = threshold hit; 0 = global-minimum fallback
//  min_value      out  INTERMEDIATE_DATA_WIDTH    entry value at tau_out
// BEHAVIOUR
//  - Reset (async): all outputs 0, FSM IDLE, snapshot/tracker registers 0. Takes effect mid-operation with no strobe.
//  - FSM states: IDLE -> SCAN -> (DESCEND) -> DONE -> IDLE.
//  - IDLE: capture on a rising edge of results_ready (registered previous value; comparison is 0->1).
//      Capture cycle C: copy results_in and threshold into snapshot registers; set busy; set idx=MIN_TAU.
//      After reset, the registered previous value is 0, so results_ready already high is taken as an edge.
//  - SCAN: one entry per cycle; entry MIN_TAU is examined at C+1.
//      Global-min tracker: update on strict < only, so the earliest index wins ties.
//      If snap[idx] < thr (strict): found=1 and go to DESCEND with idx held.
//      Else if idx==MAX_TAU-1: found=0, tau_out=min index, go to DONE.
//      Else: idx++.
//  - DESCEND: one comparison per cycle.
//      If idx+1<MAX_TAU and snap[idx+1] < snap[idx]: idx++.
//      Else: tau_out=idx, go to DONE.
//      Never reads past MAX_TAU-1.
//  - DONE: pitch_valid=1 for exactly one cycle (the cycle after the terminating comparison); busy drops that same cycle.
//      min_value=snap[tau_out]. Return to IDLE.
//      tau_out/found/min_value hold until the next strobe.
//  - Edges of results_ready while busy are ignored and not queued. A new run needs results_ready to fall and rise again.
//  - Snapshot isolation: results_in may change after C without affecting the run.
//  - Latency: hit at tau h, d descend advances -> pitch_valid at C+(h-MIN_TAU)+d+3.
//      No hit -> pitch_valid at C+(MAX_TAU-MIN_TAU)+1.
//  - Arithmetic: unsigned compares only; idx compare widened to TAU_BITS+1; no overflow paths.
// STRUCTURE
//  - Shared package yin_pkg: state encoding (IDLE/SCAN/DESCEND/DONE), TAU_BITS derivation helper,
//    and default MAX_TAU/MIN_TAU/width constants used by both this block and the difference stages.
//  - One sub-module: yin_min_tracker (running argmin: clear, valid, index, value -> min_idx, min_val;
//    strict-less update), instanced once in SCAN.
// TESTING (bench uses MAX_TAU=8, MIN_TAU=2, W=16, TAU_BITS=3)
//  1 results [x,x,100,80,30,20,25,90], thr=50, edge at C
//      -> hit at tau4, descends to 5: tau_out=5, found=1, min_value=20, pitch_valid at C+6 only.
//  2 results [x,x,90,85,70,65,60,75], thr=50
//      -> found=0, tau_out=6, min_value=60, pitch_valid at C+7.
//  3 results [x,x,90,90,90,90,40,10], thr=50
//      -> hit tau6, descend stops at boundary: tau_out=7, min_value=10, no out-of-range read (assertion).
//  4 tie: [x,x,90,55,70,55,80,95], thr=50
//      -> found=0, tau_out=3 (earliest), min_value=55.
//  5 reset asserted at C+3 mid-SCAN -> outputs 0 same cycle, no pitch_valid.
//      After reset release, a new edge runs case 1 correctly.
//  6 results_ready held high after strobe; second 0->1 pulse at C+2 while busy
//      -> exactly one pitch_valid, results_in changed at C+1 has no effect.

Source files
------------

// File: rtl/yin_pkg.sv
// Shared definitions for the YIN pitch path: picker state encoding, default
// sizing constants and the tau-width helper used by the difference stages too.
package yin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DESCEND,
    DONE
  } picker_state_t;

  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_MAX_TAU    = 40;
  localparam int DEFAULT_MIN_TAU    = 2;

  // Smallest index width that can address tau = 0..max_tau-1.
  function automatic int tau_bits_for(input int max_tau);
    return (max_tau > 1) ? $clog2(max_tau) : 1;
  endfunction

  localparam int DEFAULT_TAU_BITS = tau_bits_for(DEFAULT_MAX_TAU);

endpackage

// File: rtl/yin_min_tracker.sv
// Running argmin over a stream of (index, value) pairs. min_idx/min_val already
// include the entry presented this cycle, so a caller can finish on the last one.
module yin_min_tracker
  import yin_pkg::*;
#(
  parameter int W        = DEFAULT_DATA_WIDTH,
  parameter int TAU_BITS = DEFAULT_TAU_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                valid,
  input  logic [TAU_BITS-1:0] index,
  input  logic [W-1:0]        value,
  output logic [TAU_BITS-1:0] min_idx,
  output logic [W-1:0]        min_val
);

  logic                has_value;
  logic [TAU_BITS-1:0] best_idx;
  logic [W-1:0]        best_val;
  logic                take;

  // Strict less-than keeps the earliest index on ties.
  assign take    = valid && (!has_value || (value < best_val));
  assign min_idx = take ? index : best_idx;
  assign min_val = take ? value : best_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      has_value <= 1'b0;
      best_idx  <= '0;
      best_val  <= '0;
    end else if (clear) begin
      has_value <= 1'b0;
      best_idx  <= '0;
      best_val  <= '0;
    end else if (take) begin
      has_value <= 1'b1;
      best_idx  <= index;
      best_val  <= value;
    end
  end

endmodule

// File: rtl/yin_tau_picker.sv
// YIN period picker: snapshots a normalized-difference vector, finds the first
// sub-threshold dip and walks down to its local minimum, else the global minimum.
module yin_tau_picker
  import yin_pkg::*;
#(
  parameter int INTERMEDIATE_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_TAU                 = DEFAULT_MAX_TAU,
  parameter int MIN_TAU                 = DEFAULT_MIN_TAU,
  parameter int TAU_BITS                = DEFAULT_TAU_BITS
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [MAX_TAU*INTERMEDIATE_DATA_WIDTH-1:0] results_in,
  input  logic                                       results_ready,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0]         threshold,
  output logic                                       busy,
  output logic                                       pitch_valid,
  output logic [TAU_BITS-1:0]                        tau_out,
  output logic                                       found,
  output logic [INTERMEDIATE_DATA_WIDTH-1:0]         min_value
);

  localparam int W  = INTERMEDIATE_DATA_WIDTH;
  localparam int TW = TAU_BITS + 1;

  picker_state_t       state, state_next;
  logic [TAU_BITS-1:0] idx, idx_succ;
  logic [W-1:0]        snap [MAX_TAU];
  logic [W-1:0]        thr;
  logic                rdy_prev;
  logic                capture, at_last, has_next, below_thr, descend_more;
  logic [W-1:0]        cur_val, succ_val;
  logic [TAU_BITS-1:0] trk_min_idx;
  logic [W-1:0]        trk_min_val;

  assign capture      = (state == IDLE) && results_ready && !rdy_prev;
  assign at_last      = ({1'b0, idx} == TW'(MAX_TAU - 1));
  assign has_next     = (({1'b0, idx} + TW'(1)) < TW'(MAX_TAU));
  // The successor index saturates at the last entry so no read leaves the vector.
  assign idx_succ     = has_next ? (idx + TAU_BITS'(1)) : idx;
  assign cur_val      = snap[idx];
  assign succ_val     = snap[idx_succ];
  assign below_thr    = (cur_val < thr);
  assign descend_more = has_next && (succ_val < cur_val);

  yin_min_tracker #(
    .W        (W),
    .TAU_BITS (TAU_BITS)
  ) u_min_tracker (
    .clk     (clk),
    .reset   (reset),
    .clear   (capture),
    .valid   (state == SCAN),
    .index   (idx),
    .value   (cur_val),
    .min_idx (trk_min_idx),
    .min_val (trk_min_val)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = SCAN;
      SCAN: begin
        if (below_thr) begin
          state_next = DESCEND;
        end else if (at_last) begin
          state_next = DONE;
        end
      end
      DESCEND: if (!descend_more) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == SCAN) || (state == DESCEND);
    pitch_valid = (state == DONE);
  end

  // Results load on the terminating comparison, so they are steady for the
  // strobe cycle and hold until the next run finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_prev  <= 1'b0;
      idx       <= '0;
      thr       <= '0;
      tau_out   <= '0;
      found     <= 1'b0;
      min_value <= '0;
      for (int i = 0; i < MAX_TAU; i++) begin
        snap[i] <= '0;
      end
    end else begin
      rdy_prev <= results_ready;
      case (state)
        IDLE: begin
          if (capture) begin
            for (int i = 0; i < MAX_TAU; i++) begin
              snap[i] <= results_in[i*W +: W];
            end
            thr <= threshold;
            idx <= TAU_BITS'(MIN_TAU);
          end
        end
        SCAN: begin
          if (!below_thr) begin
            if (at_last) begin
              tau_out   <= trk_min_idx;
              found     <= 1'b0;
              min_value <= trk_min_val;
            end else begin
              idx <= idx + TAU_BITS'(1);
            end
          end
        end
        DESCEND: begin
          if (descend_more) begin
            idx <= idx_succ;
          end else begin
            tau_out   <= idx;
            found     <= 1'b1;
            min_value <= cur_val;
          end
        end
        default: ;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (reset)
    (state != IDLE) |-> ({1'b0, idx} < TW'(MAX_TAU)));

endmodule

// File: tb/tb_yin_tau_picker.sv
// Directed bench for yin_tau_picker on an 8-entry, 16-bit vector with
// hand-computed tau, found flag, minimum value and strobe latency.
module tb_yin_tau_picker;

  localparam int W        = 16;
  localparam int MAX_TAU  = 8;
  localparam int MIN_TAU  = 2;
  localparam int TAU_BITS = 3;

  logic                  clk;
  logic                  reset;
  logic [MAX_TAU*W-1:0]  results_in;
  logic                  results_ready;
  logic [W-1:0]          threshold;
  logic                  busy;
  logic                  pitch_valid;
  logic [TAU_BITS-1:0]   tau_out;
  logic                  found;
  logic [W-1:0]          min_value;

  int checks = 0;
  int errors = 0;
  int rst_strobes;

  yin_tau_picker #(
    .INTERMEDIATE_DATA_WIDTH (W),
    .MAX_TAU                 (MAX_TAU),
    .MIN_TAU                 (MIN_TAU),
    .TAU_BITS                (TAU_BITS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .results_in    (results_in),
    .results_ready (results_ready),
    .threshold     (threshold),
    .busy          (busy),
    .pitch_valid   (pitch_valid),
    .tau_out       (tau_out),
    .found         (found),
    .min_value     (min_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Entries 0 and 1 are zero so any read below MIN_TAU would win the minimum.
  task automatic setVector(input logic [W-1:0] e2, input logic [W-1:0] e3, input logic [W-1:0] e4,
                           input logic [W-1:0] e5, input logic [W-1:0] e6, input logic [W-1:0] e7);
    results_in = {e7, e6, e5, e4, e3, e2, 16'd0, 16'd0};
  endtask

  // Sample n counts cycles after the capture edge; n=1 is cycle C+1.
  task automatic applyStimulus(input string name, input logic [W-1:0] thr,
                               input logic [W-1:0] e2, input logic [W-1:0] e3, input logic [W-1:0] e4,
                               input logic [W-1:0] e5, input logic [W-1:0] e6, input logic [W-1:0] e7,
                               input int exp_latency, input int exp_tau, input int exp_found,
                               input int exp_min, input bit pulse_while_busy);
    int pv_count;
    int pv_cycle;
    pv_count = 0;
    pv_cycle = 0;
    @(negedge clk);
    setVector(e2, e3, e4, e5, e6, e7);
    threshold     = thr;
    results_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 15; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      if (n == 1) checkOutput({name, "_busy"}, busy, 1);
      if (pitch_valid) begin
        pv_count++;
        pv_cycle = n;
      end
      if (n == 1) begin
        results_ready = 1'b0;
        if (pulse_while_busy) setVector(5, 5, 5, 5, 5, 5);
      end
      if (n == 2 && pulse_while_busy) results_ready = 1'b1;
    end
    checkOutput({name, "_strobes"}, pv_count, 1);
    checkOutput({name, "_latency"}, pv_cycle, exp_latency);
    checkOutput({name, "_tau"}, {29'd0, tau_out}, exp_tau);
    checkOutput({name, "_found"}, {31'd0, found}, exp_found);
    checkOutput({name, "_min"}, {16'd0, min_value}, exp_min);
    checkOutput({name, "_idle"}, busy, 0);
    @(negedge clk);
    results_ready = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    results_ready = 1'b0;
    threshold     = '0;
    results_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", pitch_valid, 0);
    checkOutput("reset_tau", {29'd0, tau_out}, 0);
    checkOutput("reset_found", {31'd0, found}, 0);
    checkOutput("reset_min", {16'd0, min_value}, 0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("hit_descend", 50, 100, 80, 30, 20, 25, 90, 6, 5, 1, 20, 1'b0);
    applyStimulus("no_hit",      50,  90, 85, 70, 65, 60, 75, 7, 6, 0, 60, 1'b0);
    applyStimulus("edge_stop",   50,  90, 90, 90, 90, 40, 10, 8, 7, 1, 10, 1'b0);
    applyStimulus("tie",         50,  90, 55, 70, 55, 80, 95, 7, 3, 0, 55, 1'b0);

    // Reset lands mid-scan while outputs still hold the tie result.
    @(negedge clk);
    setVector(100, 80, 30, 20, 25, 90);
    threshold     = 50;
    results_ready = 1'b1;
    @(posedge clk);
    #1;
    results_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midrun_busy", busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("midrun_rst_busy", busy, 0);
    checkOutput("midrun_rst_valid", pitch_valid, 0);
    checkOutput("midrun_rst_tau", {29'd0, tau_out}, 0);
    checkOutput("midrun_rst_min", {16'd0, min_value}, 0);
    rst_strobes = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (pitch_valid) rst_strobes++;
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (pitch_valid) rst_strobes++;
    end
    checkOutput("midrun_no_strobe", rst_strobes, 0);

    applyStimulus("after_reset", 50, 100, 80, 30, 20, 25, 90, 6, 5, 1, 20, 1'b0);
    applyStimulus("busy_pulse",  50, 100, 80, 30, 20, 25, 90, 6, 5, 1, 20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
